// File: rtl/ntt_pointwise_mul_if.sv
// ntt_pointwise_mul_if
// Bundles the handshake and data signals of the pointwise multiplier.
//   in_valid/in_ready + a0..a3/b0..b3 : input vector pair (A, B)
//   out_valid/out_ready + c0..c3      : pointwise product vector C
// Handshake rule on both sides: a transfer happens at a rising clock edge
// where valid and ready are both high. The producer keeps valid and data
// steady until that edge. The consumer may change ready at any time.
// Modports:
//   master : the side that supplies operands and consumes results
//   slave  : the multiplier itself
interface ntt_pointwise_mul_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a0, a1, a2, a3;
  logic [W-1:0] b0, b1, b2, b3;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] c0, c1, c2, c3;

  modport master (
    output in_valid, a0, a1, a2, a3, b0, b1, b2, b3, out_ready,
    input  in_ready, out_valid, c0, c1, c2, c3
  );

  modport slave (
    input  in_valid, a0, a1, a2, a3, b0, b1, b2, b3, out_ready,
    output in_ready, out_valid, c0, c1, c2, c3
  );
endinterface

// File: rtl/ntt_pointwise_mul.sv
// ntt_pointwise_mul
// Pointwise product of two 4-coefficient NTT-domain vectors:
//   C[k] = (A[k] * B[k]) mod Q, k = 0..3
// One 2-stage modular multiplier is time-shared over the four coefficients:
// stage 1 forms the full 2W-bit product, stage 2 reduces it mod Q into the
// output register of the coefficient issued one edge earlier.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous, active-low reset
//   bus       : handshake/data interface (slave modport)
//   busy      : high while an operation is running or waiting to be taken
//   state_dbg : current FSM state (0 IDLE, 1 RUN, 2 HOLD)
// Q must be smaller than 2^W so every reduced result fits in W bits.
module ntt_pointwise_mul #(
  parameter int W = 16,
  parameter int Q = 7681
) (
  input  logic                clk,
  input  logic                rst,
  ntt_pointwise_mul_if.slave  bus,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [2*W-1:0] QW = (2*W)'(Q);

  state_t         state, state_next;
  logic [W-1:0]   a_q [4];
  logic [W-1:0]   b_q [4];
  logic [W-1:0]   c_q [4];
  // idx counts 0..4; the value 4 means all four products have been issued
  // and only the last reduction is still pending.
  logic [2:0]     idx;
  logic [2*W-1:0] prod;
  logic [1:0]     prod_idx;
  logic           prod_valid;
  logic           accept;

  assign accept = (state == IDLE) && bus.in_valid;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.in_valid)   state_next = RUN;
      RUN:  if (idx == 3'd4)    state_next = HOLD;
      HOLD: if (bus.out_ready)  state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Operand latches, multiplier pipeline and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        c_q[k] <= '0;
      end
      idx        <= '0;
      prod       <= '0;
      prod_idx   <= '0;
      prod_valid <= 1'b0;
    end else begin
      if (accept) begin
        a_q[0] <= bus.a0;
        a_q[1] <= bus.a1;
        a_q[2] <= bus.a2;
        a_q[3] <= bus.a3;
        b_q[0] <= bus.b0;
        b_q[1] <= bus.b1;
        b_q[2] <= bus.b2;
        b_q[3] <= bus.b3;
        idx        <= '0;
        prod_valid <= 1'b0;
      end else if (state == RUN) begin
        // Stage 1: issue the next coefficient while any remain.
        if (idx != 3'd4) begin
          prod       <= (2*W)'(a_q[idx[1:0]]) * (2*W)'(b_q[idx[1:0]]);
          prod_idx   <= idx[1:0];
          prod_valid <= 1'b1;
          idx        <= idx + 3'd1;
        end else begin
          prod_valid <= 1'b0;
        end
        // Stage 2: reduce the product issued on the previous edge.
        if (prod_valid) begin
          c_q[prod_idx] <= W'(prod % QW);
        end
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == HOLD);
  assign bus.c0        = c_q[0];
  assign bus.c1        = c_q[1];
  assign bus.c2        = c_q[2];
  assign bus.c3        = c_q[3];
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_ntt_pointwise_mul.sv
// tb_ntt_pointwise_mul
// Directed vectors with hand-computed products mod 7681. The driver pushes
// the expected C vector when an input pair is accepted; an independent
// monitor pops and compares on every output handshake, and also watches
// output latency, hold stability and ready behaviour around handshakes.
module tb_ntt_pointwise_mul;
  localparam int W = 16;

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       busy;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  ntt_pointwise_mul_if #(.W(W)) bus();

  ntt_pointwise_mul #(.W(W), .Q(7681)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Bookkeeping
  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  int          cycle = 0;
  int          accept_edge = -1;
  int          prev_accept = -1;
  int          drv_accepts = 0;
  int          dut_accepts = 0;
  logic        prev_ov = 1'b0;
  logic        hs_last = 1'b0;
  logic [63:0] held = '0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  function automatic logic [63:0] pk(input int v0, input int v1, input int v2, input int v3);
    return {16'(v3), 16'(v2), 16'(v1), 16'(v0)};
  endfunction

  function automatic logic [63:0] cur_c();
    return {bus.c3, bus.c2, bus.c1, bus.c0};
  endfunction

  // Driver: call at a negedge. Leaves in_valid high on return so pairs can
  // be chained back to back; the caller drops it when done.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    int n;
    bus.a0 = a[15:0];  bus.a1 = a[31:16]; bus.a2 = a[47:32]; bus.a3 = a[63:48];
    bus.b0 = b[15:0];  bus.b1 = b[31:16]; bus.b2 = b[47:32]; bus.b3 = b[63:48];
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      accept_edge = cycle + 1;
      if (prev_accept >= 0)
        check("accept_gap_ge6", 64'(accept_edge - prev_accept >= 6), 64'd1);
      prev_accept = accept_edge;
      exp_q.push_back(exp);
      drv_accepts++;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        prev_ov = 1'b0;
        hs_last = 1'b0;
      end else begin
        if (hs_last) begin
          check("in_ready_after_hs", 64'(bus.in_ready), 64'd1);
          check("out_valid_after_hs", 64'(bus.out_valid), 64'd0);
        end
        hs_last = 1'b0;
        if (bus.in_valid && bus.in_ready) dut_accepts++;
        if (bus.out_valid) begin
          check("in_ready_low_in_hold", 64'(bus.in_ready), 64'd0);
          if (!prev_ov) begin
            check("latency", 64'(cycle - accept_edge), 64'd5);
            held = cur_c();
          end else begin
            check("hold_stable", cur_c(), held);
          end
          if (bus.out_ready) begin
            if (exp_q.size() == 0) check("unexpected_output", 64'd1, 64'd0);
            else check("result", cur_c(), exp_q.pop_front());
            hs_last = 1'b1;
          end
        end
        prev_ov = bus.out_valid;
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a0 = '0; bus.a1 = '0; bus.a2 = '0; bus.a3 = '0;
    bus.b0 = '0; bus.b1 = '0; bus.b2 = '0; bus.b3 = '0;

    // Reset then idle
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_c", cur_c(), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);

    // Basic products
    send(pk(1925, 2, 0, 7680), pk(3383, 3, 1234, 7680), pk(6468, 6, 0, 1));
    bus.in_valid = 1'b0;
    check("busy_in_run", 64'(busy), 64'd1);
    drain();

    // Non-reduced inputs
    send(pk(65535, 7681, 1, 65535), pk(65535, 5, 7681, 1), pk(5075, 0, 0, 4087));
    bus.in_valid = 1'b0;
    drain();

    // Backpressure with ignored input pulses
    bus.out_ready = 1'b0;
    send(pk(100, 200, 300, 400), pk(5, 6, 7, 8), pk(500, 1200, 2100, 3200));
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.a0 = 16'($urandom_range(0, 65535)); bus.a1 = 16'($urandom_range(0, 65535));
      bus.a2 = 16'($urandom_range(0, 65535)); bus.a3 = 16'($urandom_range(0, 65535));
      bus.b0 = 16'($urandom_range(0, 65535)); bus.b1 = 16'($urandom_range(0, 65535));
      bus.b2 = 16'($urandom_range(0, 65535)); bus.b3 = 16'($urandom_range(0, 65535));
      @(negedge clk);
      check("bp_busy", 64'(busy), 64'd1);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    drain();

    // Reset mid-operation
    send(pk(1, 2, 3, 4), pk(5, 6, 7, 8), pk(5, 12, 21, 32));
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_c", cur_c(), 64'd0);
    check("abort_state", 64'(state_dbg), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(pk(1925, 2, 0, 7680), pk(3383, 3, 1234, 7680), pk(6468, 6, 0, 1));
    bus.in_valid = 1'b0;
    drain();

    // Back-to-back with in_valid held high
    send(pk(100, 200, 300, 400), pk(5, 6, 7, 8), pk(500, 1200, 2100, 3200));
    send(pk(7680, 1000, 4000, 12345), pk(2, 1000, 4000, 1), pk(7679, 1470, 477, 4664));
    send(pk(65535, 7681, 1, 65535), pk(65535, 5, 7681, 1), pk(5075, 0, 0, 4087));
    bus.in_valid = 1'b0;
    drain();

    check("accept_count", 64'(dut_accepts), 64'(drv_accepts));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ntt_pointwise_mul.md
Name: ntt_pointwise_mul

Overview:
- Downstream consumer of the 4-point NTT stage. Takes two 4-coefficient NTT-domain vectors (A, B), each coefficient 16 bits, modulus Q = 7681.
- Produces the pointwise product C[k] = (A[k]*B[k]) mod Q, which is the convolution step between forward NTT and INTT.
- Time-multiplexes one 2-stage pipelined modular multiplier over the 4 coefficients.
- Uses valid/ready handshakes on both the input and output sides.

Parameters:
- W, 16: coefficient width.
- Q, 7681: modulus. Must satisfy Q < 2^W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset. 0 resets the block.
- in_valid  in  1  a0..a3/b0..b3 are valid.
- in_ready  out  1  block can accept a vector pair.
- a0, a1, a2, a3  in  W each  vector A, natural order.
- b0, b1, b2, b3  in  W each  vector B, natural order.
- out_valid  out  1  c0..c3 are valid.
- out_ready  in  1  downstream accepts c0..c3.
- c0, c1, c2, c3  out  W each  pointwise products mod Q.
- busy  out  1  high in RUN or HOLD.

Behaviour:
- Reset (rst=0, async): state=IDLE; in_ready=1; out_valid=0; busy=0; c0..c3=0; all internal regs (operand latches, idx, product reg, pipeline valid) = 0. Reset mid-RUN or mid-HOLD aborts the operation with no output.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready at an edge (edge E0): latch a0..a3 and b0..b3, idx<=0, go to RUN.
  - RUN: in_ready=0. At edges E1..E4, prod <= A[idx]*B[idx] as a full 2W-bit unsigned product; idx increments 0->3.
    - At edges E2..E5, c[k] <= prod mod Q, for k = the idx issued one edge earlier.
    - At E5 (last write), state<=HOLD and out_valid<=1.
  - HOLD: out_valid=1; c0..c3 stable. On out_valid&&out_ready at an edge: out_valid<=0, state<=IDLE, in_ready=1 from that cycle on. c0..c3 keep their values until overwritten.
- Latency: out_valid rises in the cycle following E5, i.e. 5 clock edges after the accept edge. Throughput is one vector pair per ≥6 cycles; there is no overlap of operations.
- in_valid and input data are ignored outside IDLE. Latched operands are immune to input changes after E0.
- out_ready may stay low indefinitely; the block holds HOLD with stable outputs. out_ready is don't-care outside HOLD.
- Arithmetic:
  - Product register is 2W bits; reduction is exact mod Q.
  - Result is always < Q, including for non-reduced inputs (any 16-bit value).
  - c[k] is written only from the stage-2 register; there is no combinational path from inputs to outputs.
- c0..c3 update only during RUN writes; during HOLD they are never modified.
- No simultaneous accept and release is possible: in_ready=0 whenever out_valid=1.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release -> in_ready=1, out_valid=0, c0..c3=0, busy=0.
- Basic products: A=(1925, 2, 0, 7680), B=(3383, 3, 1234, 7680), out_ready=1 -> out_valid exactly 5 edges after accept with C=(6468, 6, 0, 1). in_ready returns to 1 the cycle after the handshake.
- Non-reduced inputs: A=(65535, 7681, 1, 65535), B=(65535, 5, 7681, 1) -> C=(5075, 0, 0, 4087).
- Backpressure: out_ready=0 for 10 cycles after out_valid -> C stable, in_ready=0; in_valid pulses with new data are ignored. Raise out_ready -> one-cycle handshake, then IDLE.
- Reset mid-operation: drop rst 3 edges after accept -> out_valid=0, c0..c3=0, state IDLE. A fresh vector pair afterwards gives correct results.
- Back-to-back: in_valid held high with 3 different vector pairs and out_ready=1 -> each is accepted exactly once. Results arrive in order, and each accept is ≥6 cycles apart.
